instr_split_stage: RTL and testbench

Parametrised, buffered MIPS instruction field splitter for the decode front end. It accepts one 32-bit instruction plus its PC per cycle over a valid/ready handshake and holds them in a DEPTH-entry FIFO. From the FIFO head it presents all R/I/J fields, a mode-selected extended immediate and, when enabled, branch and jump targets. It sits between instruction fetch and the register-file/control stage, absorbing backpressure that the bare combinational splitter could not.

---
 rtl/instr_split_stage.sv | 127 ++++++++++++
 tb/tb_instr_split_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_split_stage.sv
// Buffered MIPS instruction field splitter: DEPTH-entry FIFO of {instr, pc, ext_mode} with fields decoded from the head.
// Define INSTR_SPLIT_TARGET_EN to build the branch/jump target adders and the pc storage they need.
`timescale 1ns/1ps
module instr_split_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [1:0]                   in_ext_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [5:0]                   opcode,
  output logic [4:0]                   rs,
  output logic [4:0]                   rt,
  output logic [4:0]                   rd,
  output logic [4:0]                   shamt,
  output logic [5:0]                   funct,
  output logic [15:0]                  imm,
  output logic [25:0]                  imm1,
  output logic [XLEN-1:0]              ext_imm,
  output logic [XLEN-1:0]              br_target,
  output logic [XLEN-1:0]              j_target,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   r_instr_mem [DEPTH];
  logic [1:0]    r_mode_mem  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_instr;
  logic [1:0]    w_head_mode;
  logic [XLEN-1:0] w_imm_zext;
  logic [XLEN-1:0] w_imm_sext;

  // No pass-through: a full FIFO refuses input even when the head is popped this cycle.
  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= in_instr;
      r_mode_mem[r_wr_ptr]  <= in_ext_mode;
    end
  end

  assign w_head_instr = out_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
  assign w_head_mode  = out_valid ? r_mode_mem[r_rd_ptr]  : 2'b00;

  assign opcode = w_head_instr[31:26];
  assign rs     = w_head_instr[25:21];
  assign rt     = w_head_instr[20:16];
  assign rd     = w_head_instr[15:11];
  assign shamt  = w_head_instr[10:6];
  assign funct  = w_head_instr[5:0];
  assign imm    = w_head_instr[15:0];
  assign imm1   = w_head_instr[25:0];

  assign w_imm_zext = {{(XLEN-16){1'b0}}, w_head_instr[15:0]};
  assign w_imm_sext = {{(XLEN-16){w_head_instr[15]}}, w_head_instr[15:0]};

  always_comb begin
    ext_imm = w_imm_zext;
    case (w_head_mode)
      2'b00: ext_imm = w_imm_zext;
      2'b01: ext_imm = w_imm_sext;
      2'b10: ext_imm = w_imm_zext << 16;
      2'b11: ext_imm = w_imm_sext << 2;
      default: ext_imm = w_imm_zext;
    endcase
  end

`ifdef INSTR_SPLIT_TARGET_EN
  logic [XLEN-1:0] r_pc_mem [DEPTH];
  logic [XLEN-1:0] w_head_pc;
  logic [XLEN-1:0] w_pc4;

  always_ff @(posedge clk) begin
    if (w_push) r_pc_mem[r_wr_ptr] <= in_pc;
  end

  assign w_head_pc = out_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign w_pc4     = w_head_pc + XLEN'(4);

  // Gated explicitly: an empty head would otherwise show pc+4 on the branch target.
  assign br_target = out_valid ? (w_pc4 + (w_imm_sext << 2)) : '0;
  assign j_target  = out_valid ? {w_pc4[XLEN-1:28], w_head_instr[25:0], 2'b00} : '0;
`else
  logic w_unused_pc;

  assign w_unused_pc = ^in_pc;
  assign br_target   = '0;
  assign j_target    = '0;
`endif

endmodule

// File: tb/tb_instr_split_stage.sv
// Self-checking bench for instr_split_stage: queue-based reference model compared every cycle,
// plus directed literal expectations and randomized traffic with occasional resets.
`timescale 1ns/1ps
module tb_instr_split_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [1:0]      in_ext_mode;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd, shamt;
  logic [5:0]      funct;
  logic [15:0]     imm;
  logic [25:0]     imm1;
  logic [XLEN-1:0] ext_imm, br_target, j_target;
  logic [CW-1:0]   count;

  instr_split_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_ext_mode(in_ext_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .imm1(imm1), .ext_imm(ext_imm),
    .br_target(br_target), .j_target(j_target), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  mode;
  } ent_t;

  ent_t q[$];
  bit   started = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_sext(input logic [31:0] instr);
    logic [31:0] v;
    v = instr % 65536;
    if (v >= 32768) v = v + 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] instr, input logic [1:0] mode);
    logic [31:0] v;
    v = instr % 65536;
    case (mode)
      2'd0: return v;
      2'd1: return m_sext(instr);
      2'd2: return v * 65536;
      default: return m_sext(instr) * 4;
    endcase
  endfunction

  // Reference model: a plain queue updated on each rising edge.
  always @(posedge clk) begin
    bit   do_push, do_pop;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      started = 1;
    end else if (started) begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && out_ready;
      e.instr = in_instr;
      e.pc    = in_pc;
      e.mode  = in_ext_mode;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    ent_t        h;
    logic [31:0] e_br, e_j;
    if (started) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      if (q.size() != 0) begin
        h = q[0];
      end else begin
        h.instr = 0; h.pc = 0; h.mode = 0;
      end
      chk("opcode", 64'(opcode), 64'(h.instr / 67108864));
      chk("rs", 64'(rs), 64'((h.instr / 2097152) % 32));
      chk("rt", 64'(rt), 64'((h.instr / 65536) % 32));
      chk("rd", 64'(rd), 64'((h.instr / 2048) % 32));
      chk("shamt", 64'(shamt), 64'((h.instr / 64) % 32));
      chk("funct", 64'(funct), 64'(h.instr % 64));
      chk("imm", 64'(imm), 64'(h.instr % 65536));
      chk("imm1", 64'(imm1), 64'(h.instr % 67108864));
      chk("ext_imm", 64'(ext_imm), 64'(m_ext(h.instr, h.mode)));
      e_br = 0;
      e_j  = 0;
`ifdef INSTR_SPLIT_TARGET_EN
      if (q.size() != 0) begin
        e_br = h.pc + 4 + m_sext(h.instr) * 4;
        e_j  = ((h.pc + 4) & 32'hF000_0000) | ((h.instr % 67108864) * 4);
      end
`endif
      chk("br_target", 64'(br_target), 64'(e_br));
      chk("j_target", 64'(j_target), 64'(e_j));
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [1:0] m, input logic rdy);
    in_valid    = v;
    in_instr    = ins;
    in_pc       = pc;
    in_ext_mode = m;
    out_ready   = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ext_tab [4];
  logic [1:0]  mode_tab [4];
  logic [31:0] seq_w [3];
  logic [31:0] wv;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    mode_tab[0] = 2'd1; ext_tab[0] = 32'hFFFF_FFFC;
    mode_tab[1] = 2'd0; ext_tab[1] = 32'h0000_FFFC;
    mode_tab[2] = 2'd2; ext_tab[2] = 32'hFFFC_0000;
    mode_tab[3] = 2'd3; ext_tab[3] = 32'hFFFF_FFF0;
    seq_w[0] = 32'h2001_0001; seq_w[1] = 32'h2002_0002; seq_w[2] = 32'h2003_0003;

    step(); step();
    rst_n = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ext_imm", 64'(ext_imm), 64'd0);

    // R-type split
    drive(1, 32'h012A_4020, 32'h0040_0000, 2'd0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk("r_out_valid", 64'(out_valid), 64'd1);
    chk("r_opcode", 64'(opcode), 64'd0);
    chk("r_rs", 64'(rs), 64'd9);
    chk("r_rt", 64'(rt), 64'd10);
    chk("r_rd", 64'(rd), 64'd8);
    chk("r_shamt", 64'(shamt), 64'd0);
    chk("r_funct", 64'(funct), 64'h20);
    chk("r_count", 64'(count), 64'd1);
    drive(0, 0, 0, 0, 1);
    step();

    // Extension modes
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h2128_FFFC, 32'h0, mode_tab[i], 0);
      step();
      drive(0, 0, 0, 0, 0);
      chk("ext_mode_lit", 64'(ext_imm), 64'(ext_tab[i]));
      drive(0, 0, 0, 0, 1);
      step();
    end

    // Branch and jump targets
    drive(1, 32'h1109_FFFF, 32'h0040_0010, 2'd1, 0);
    step();
    drive(0, 0, 0, 0, 1);
`ifdef INSTR_SPLIT_TARGET_EN
    chk("br_lit", 64'(br_target), 64'h0040_0010);
`else
    chk("br_lit", 64'(br_target), 64'h0);
`endif
    step();
    drive(1, 32'h0810_0004, 32'h0040_0000, 2'd0, 0);
    step();
    drive(0, 0, 0, 0, 1);
`ifdef INSTR_SPLIT_TARGET_EN
    chk("j_lit", 64'(j_target), 64'h0040_0010);
`else
    chk("j_lit", 64'(j_target), 64'h0);
`endif
    step();

    // Fill to full, hold the third, then drain in order
    drive(1, seq_w[0], 32'h100, 2'd0, 0);
    step();
    in_instr = seq_w[1];
    step();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd2);
    in_instr = seq_w[2];
    step();
    chk("held_count", 64'(count), 64'd2);
    chk("held_head", 64'({opcode, imm1}), 64'(seq_w[0]));
    out_ready = 1'b1;
    step();
    chk("pop1_in_ready", 64'(in_ready), 64'd1);
    chk("order2", 64'({opcode, imm1}), 64'(seq_w[1]));
    step();
    in_valid = 1'b0;
    chk("order3", 64'({opcode, imm1}), 64'(seq_w[2]));
    chk("order3_count", 64'(count), 64'd1);
    step();
    chk("drained", 64'(out_valid), 64'd0);

    // Streaming, one per cycle
    for (int i = 0; i < 10; i++) begin
      wv = 32'h0C00_0000 + 32'(i * 37);
      drive(1, wv, 32'(i * 4), 2'(i), 1);
      step();
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_head", 64'({opcode, imm1}), 64'(wv));
    end
    drive(0, 0, 0, 0, 1);
    step();
    chk("stream_drained", 64'(count), 64'd0);

    // Mid-operation reset
    drive(1, 32'hDEAD_BEEF, 32'h40, 2'd1, 0);
    step(); step();
    chk("pre_rst_count", 64'(count), 64'd2);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1);
    step();
    rst_n = 1'b1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      step();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1);
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
